// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package cla_seq_pkg;

  // Width of the shared carry-lookahead slice; the sequencer walks the operands in steps of this size
  localparam int NIB_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_addsub_seq_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// Performs no operand inversion; the sequencer supplies ~b and carry-in=1 for subtraction.
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             c3,
  output logic             c4
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic             w_c1;
  logic             w_c2;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is expanded directly from generate/propagate terms so none waits on a lower carry
  always_comb begin
    w_c1 = w_g[0] | (w_p[0] & cin);
    w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
         | (w_p[2] & w_p[1] & w_p[0] & cin);
    c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
         | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
         | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
    sum  = w_p ^ {c3, w_c2, w_c1, cin};
  end

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared 4-bit CLA slice,
// stepping one nibble per cycle LSB first with valid/ready on both sides.
// WIDTH must be a multiple of 4 and at least 4.
// Optional macro CLA_SEQ_ABORT_EN adds an 'abort' input that cancels a
// command in RUN or DONE and clears the result outputs.
module cla_addsub_seq
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CLA_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIB_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_areg;
  logic [WIDTH-1:0] r_breg;
  logic [WIDTH-1:0] r_res;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [NIB_W-1:0] w_aNib;
  logic [NIB_W-1:0] w_bNib;
  logic [NIB_W-1:0] w_sliceSum;
  logic             w_sliceC3;
  logic             w_sliceC4;
  logic             w_last;

  assign w_aNib = r_areg[NIB_W*r_idx +: NIB_W];
  assign w_bNib = r_breg[NIB_W*r_idx +: NIB_W];
  assign w_last = (r_idx == LAST_IDX);

  cla4_slice u_slice (
    .a   (w_aNib),
    .b   (w_bNib),
    .cin (r_carry),
    .sum (w_sliceSum),
    .c3  (w_sliceC3),
    .c4  (w_sliceC4)
  );

  assign start_ready = (r_state == IDLE);
  assign done_valid  = (r_state == DONE);
  assign res         = r_res;
  assign cout        = r_cout;
  assign ovf         = r_ovf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next state: accept in IDLE, leave RUN after the top nibble, release DONE on consumer ready
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start_valid) w_nextState = RUN;
      RUN:     if (w_last)      w_nextState = DONE;
      DONE:    if (done_ready)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
`ifdef CLA_SEQ_ABORT_EN
    if (abort && (r_state != IDLE)) w_nextState = IDLE;
`endif
  end

  // Datapath: latch operands at accept, then fold one slice result per cycle into res and carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_areg  <= '0;
      r_breg  <= '0;
      r_res   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else
`ifdef CLA_SEQ_ABORT_EN
    if (abort && (r_state != IDLE)) begin
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else
`endif
    begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_areg  <= a;
            r_breg  <= (op == OP_SUB) ? ~b : b;
            r_carry <= op;
            r_idx   <= '0;
            r_res   <= '0;
          end
        end
        RUN: begin
          r_res[NIB_W*r_idx +: NIB_W] <= w_sliceSum;
          r_carry <= w_sliceC4;
          if (w_last) begin
            r_cout <= w_sliceC4;
            r_ovf  <= w_sliceC3 ^ w_sliceC4;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Self-checking bench for cla_addsub_seq (WIDTH=16). An arithmetic reference
// model tracks what the outputs must be; a compare process checks them every
// cycle, and directed vectors pin the model with hand-computed literals.
// Define CLA_SEQ_ABORT_EN for the abort scenario as well.
module tb_cla_addsub_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             done_valid;
  logic             done_ready = 1'b0;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
`ifdef CLA_SEQ_ABORT_EN
  logic             abort = 1'b0;
`endif

  int checkCount = 0;
  int errCount   = 0;

  // Reference model state: busy countdown, done flag and visible result
  logic             mBusy = 1'b0;
  logic             mDone = 1'b0;
  int               mCnt  = 0;
  logic [WIDTH-1:0] mRes  = '0;
  logic             mCout = 1'b0;
  logic             mOvf  = 1'b0;
  logic [WIDTH+1:0] mPend = '0;

  cla_addsub_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .a           (a),
    .b           (b),
`ifdef CLA_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .res         (res),
    .cout        (cout),
    .ovf         (ovf)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Plain-arithmetic reference: returns {result, carry-out, signed overflow}
  function automatic logic [WIDTH+1:0] refCalc(input logic o, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] r;
    logic             v;
    if (o) full = {1'b0, x} + {1'b0, ~y} + 17'd1;
    else   full = {1'b0, x} + {1'b0, y};
    r = full[WIDTH-1:0];
    if (o) v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    else   v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    return {r, full[WIDTH], v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a command occupies NIB cycles, then holds the result until taken
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mCnt  <= 0;
      mRes  <= '0;
      mCout <= 1'b0;
      mOvf  <= 1'b0;
    end
`ifdef CLA_SEQ_ABORT_EN
    else if (abort && (mBusy || mDone)) begin
      mBusy <= 1'b0;
      mDone <= 1'b0;
      mRes  <= '0;
      mCout <= 1'b0;
      mOvf  <= 1'b0;
    end
`endif
    else if (mBusy) begin
      if (mCnt == 1) begin
        mBusy <= 1'b0;
        mDone <= 1'b1;
        mRes  <= mPend[WIDTH+1:2];
        mCout <= mPend[1];
        mOvf  <= mPend[0];
      end
      mCnt <= mCnt - 1;
    end else if (mDone) begin
      if (done_ready) mDone <= 1'b0;
    end else if (start_valid) begin
      mBusy <= 1'b1;
      mCnt  <= NIB;
      mPend <= refCalc(op, a, b);
      mRes  <= '0;
    end
  end

  // Compare DUT against the model on every falling edge outside reset
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("start_ready", {31'd0, start_ready}, {31'd0, !mBusy && !mDone});
      checkOutput("done_valid", {31'd0, done_valid}, {31'd0, mDone});
      if (!mBusy) begin
        checkOutput("res", {16'd0, res}, {16'd0, mRes});
        checkOutput("cout", {31'd0, cout}, {31'd0, mCout});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, mOvf});
      end
    end
  end

  // Present a command and hold it until the accepting edge, then scramble the inputs
  task automatic issueCmd(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int guard = 0;
    while (!start_ready && guard < 40) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!start_ready) checkOutput("start_ready timeout", 32'd0, 32'd1);
    start_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk); #2;
    start_valid = 1'b0;
    a  = 16'($urandom);
    b  = 16'($urandom);
    op = 1'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!done_valid && lat < 40) begin
      @(posedge clk); #2;
      lat++;
    end
    if (!done_valid) checkOutput("done_valid timeout", 32'd0, 32'd1);
  endtask

  // Full transaction with literal expectations, latency check and hand-off
  task automatic applyStimulus(input logic o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic [WIDTH-1:0] expR, input logic expC, input logic expV);
    int lat;
    issueCmd(o, x, y);
    waitDone(lat);
    checkOutput("latency", lat, NIB);
    checkOutput("res literal", {16'd0, res}, {16'd0, expR});
    checkOutput("cout literal", {31'd0, cout}, {31'd0, expC});
    checkOutput("ovf literal", {31'd0, ovf}, {31'd0, expV});
    done_ready = 1'b1;
    @(posedge clk); #2;
    done_ready = 1'b0;
    checkOutput("start_ready after take", {31'd0, start_ready}, 32'd1);
    checkOutput("done_valid after take", {31'd0, done_valid}, 32'd0);
    checkOutput("res held after take", {16'd0, res}, {16'd0, expR});
  endtask

  initial begin
    int lat;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset res", {16'd0, res}, 32'd0);
    checkOutput("reset done_valid", {31'd0, done_valid}, 32'd0);
    checkOutput("reset start_ready", {31'd0, start_ready}, 32'd1);
    checkOutput("reset cout", {31'd0, cout}, 32'd0);
    checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #2;

    $display("[TB] add / subtract / overflow vectors");
    applyStimulus(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    applyStimulus(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);

    $display("[TB] reset in the middle of RUN");
    issueCmd(1'b0, 16'h00F0, 16'h0F0F);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midrun reset res", {16'd0, res}, 32'd0);
    checkOutput("midrun reset cout", {31'd0, cout}, 32'd0);
    checkOutput("midrun reset done_valid", {31'd0, done_valid}, 32'd0);
    checkOutput("midrun reset start_ready", {31'd0, start_ready}, 32'd1);
    #1 rst = 1'b0;
    @(posedge clk); #2;
    applyStimulus(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    $display("[TB] backpressure on the result side");
    issueCmd(1'b0, 16'h1234, 16'h0FFF);
    waitDone(lat);
    checkOutput("bp latency", lat, NIB);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      start_valid = 1'b0;
      checkOutput("bp res stable", {16'd0, res}, 32'h2233);
      checkOutput("bp start_ready", {31'd0, start_ready}, 32'd0);
      checkOutput("bp done_valid", {31'd0, done_valid}, 32'd1);
      if (i == 1) begin
        start_valid = 1'b1;
        op = 1'b1;
        a  = 16'hAAAA;
        b  = 16'h5555;
      end
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk); #2;
    done_ready = 1'b0;
    checkOutput("bp release start_ready", {31'd0, start_ready}, 32'd1);
    checkOutput("bp release res", {16'd0, res}, 32'h2233);
    applyStimulus(1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0);

`ifdef CLA_SEQ_ABORT_EN
    $display("[TB] abort during RUN");
    issueCmd(1'b0, 16'h1111, 16'h2222);
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    checkOutput("abort start_ready", {31'd0, start_ready}, 32'd1);
    checkOutput("abort res", {16'd0, res}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      checkOutput("abort no done", {31'd0, done_valid}, 32'd0);
    end
    applyStimulus(1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cla_addsub_seq.md
Name: cla_addsub_seq

Overview:
- Multi-cycle WIDTH-bit add/subtract sequencer built on one shared 4-bit carry-lookahead slice.
- Steps the slice over the operand nibbles, LSB first, carrying between steps.
- Valid/ready handshake on the command side and on the result side.
- Sits between the control path and narrow ALU resources; trades latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived constant: number of slice steps; not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start_valid  input  1  command present
- start_ready  output  1  block can accept a command
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled at accept
- a  input  WIDTH  operand A; sampled at accept
- b  input  WIDTH  operand B; sampled at accept
- done_valid  output  1  result valid
- done_ready  input  1  consumer takes the result
- res  output  WIDTH  sum/difference, modulo 2^WIDTH
- cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned)
- ovf  output  1  two's-complement overflow

Behaviour:
- Reset is asynchronous, active-high: state=IDLE, idx=0, carry=0, res=0, cout=0, ovf=0, done_valid=0.
- start_ready is high only in IDLE. It is a combinational decode of the state.
- Accept happens on a clock edge with start_valid && start_ready. At accept:
  - latch a into areg;
  - latch b into breg, inverted (~b) when op=1;
  - carry <= op; idx <= 0; res <= 0; state <= RUN.
- RUN, one nibble per cycle. The slice sees areg[4*idx+:4], breg[4*idx+:4] and carry. On each edge:
  - res[4*idx+:4] <= slice sum;
  - carry <= slice c4.
- Slice carry equations: g=a&b, p=a^b, c1..c4 full lookahead, sum = p ^ {c3,c2,c1,c0}.
- On the edge with idx == NIB-1:
  - cout <= c4;
  - ovf <= c3 ^ c4 of the top nibble;
  - state <= DONE. Otherwise idx <= idx+1.
- DONE: done_valid=1. res, cout and ovf hold stable until the edge where done_ready=1.
  - On that edge: state <= IDLE, done_valid drops.
  - res, cout and ovf keep their values after the drop and are overwritten only at the next accept.
- Latency: accept at edge k puts done_valid high from edge k+NIB. Minimum command-to-command spacing is NIB+2 cycles.
- start_valid during RUN or DONE is ignored; the command is not accepted and not queued.
- done_ready outside DONE has no effect.
- a, b and op changes after accept have no effect.
- WIDTH=4 (NIB=1): RUN lasts exactly one cycle.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values; the partial result is discarded.

Optional Feature:
- Macro: CLA_SEQ_ABORT_EN.
- Defined: adds port abort (input, 1). abort=1 in RUN or DONE gives, on the next edge:
  - state <= IDLE;
  - res, cout and ovf cleared to 0;
  - done_valid low.
- abort has priority over done_ready and over the last-nibble update. abort in IDLE is ignored, and the same-edge accept still occurs.
- Not defined: no abort port, no abort logic.

Decomposition:
- Package cla_seq_pkg holds:
  - state enum {IDLE, RUN, DONE} (2 bits);
  - localparam OP_ADD=1'b0, OP_SUB=1'b1;
  - the nibble-width constant 4.
- Sub-module cla4_slice: purely combinational. Inputs a[3:0], b[3:0], cin. Outputs sum[3:0], c3 (carry into bit 3), c4.
  - It performs no internal inversion; subtraction is handled entirely by the sequencer's ~b and carry-in=1.

Test Plan:
All cases use WIDTH=16.
- Add with carry chain: add, a=0x1234, b=0x0FFF -> res=0x2233, cout=0, ovf=0; done_valid exactly 4 edges after accept.
- Subtract with borrow: sub, a=0x0005, b=0x0007 -> res=0xFFFE, cout=0, ovf=0. Also sub, a=0x0007, b=0x0005 -> res=0x0002, cout=1.
- Signed overflow and wrap:
  - add, 0x7FFF+0x0001 -> res=0x8000, ovf=1, cout=0;
  - add, 0xFFFF+0x0001 -> res=0x0000, cout=1, ovf=0;
  - sub, 0x8000-0x0001 -> res=0x7FFF, ovf=1.
- Backpressure:
  - hold done_ready=0 for 5 cycles: res, cout and ovf stable, start_ready=0;
  - a start_valid pulse during this window is not accepted;
  - done_ready=1 returns to IDLE next edge, with start_ready=1.
- Reset mid-op: assert rst after the 2nd RUN cycle -> outputs zero immediately; the next command 0x0001+0x0001 yields 0x0002.
- Abort (CLA_SEQ_ABORT_EN defined): abort in the 3rd RUN cycle -> IDLE next edge, res=0, done_valid never asserts.
